// File: rtl/ball_mover.sv
// rtl/ball_mover.sv - ball position/direction tracker with platform, wall and brick bounces
module ball_mover #(
    parameter logic [9:0] MAX_X   = 10'd159,
    parameter logic [9:0] MAX_Y   = 10'd119,
    parameter logic [9:0] PLATY   = 10'd110,
    parameter logic [9:0] PLAT_W  = 10'd20,
    parameter logic [9:0] START_Y = 10'd109
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tick,
    input  logic       launch,
    input  logic       respawn,
    input  logic [9:0] plat_x,
    input  logic       hit_x,
    input  logic       hit_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [1:0] state,
    output logic       lost_pulse
);

    localparam logic [1:0]  ST_PARKED  = 2'b00;
    localparam logic [1:0]  ST_MOVING  = 2'b01;
    localparam logic [1:0]  ST_LOST    = 2'b10;
    localparam logic [9:0]  RESET_X    = 10'd80;
    localparam logic [9:0]  PLAT_ABOVE = PLATY - 10'd1;
    localparam logic [10:0] HALF_W     = {2'b00, PLAT_W[9:1]};

    logic [1:0] state_q, state_d;
    logic [9:0] ball_x_q, ball_x_d;
    logic [9:0] ball_y_q, ball_y_d;
    logic       dir_x_q, dir_x_d;
    logic       dir_y_q, dir_y_d;
    logic       lost_pulse_q, lost_pulse_d;

    // Platform span math is done in 11 bits so a platform near the top of the range never wraps.
    logic [10:0] park_sum;
    logic [10:0] plat_hi;
    logic [9:0]  park_x;
    logic        on_plat;
    logic        eff_dx;
    logic        eff_dy;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_PARKED;
            ball_x_q     <= RESET_X;
            ball_y_q     <= START_Y;
            dir_x_q      <= 1'b1;
            dir_y_q      <= 1'b0;
            lost_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            lost_pulse_q <= lost_pulse_d;
        end
    end

    always_comb begin
        park_sum = {1'b0, plat_x} + HALF_W;
        plat_hi  = {1'b0, plat_x} + {1'b0, PLAT_W} - 11'd1;
        park_x   = (park_sum > {1'b0, MAX_X}) ? MAX_X : park_sum[9:0];
        on_plat  = ({1'b0, ball_x_q} >= {1'b0, plat_x}) && ({1'b0, ball_x_q} <= plat_hi);
        eff_dx   = dir_x_q ^ hit_x;
        eff_dy   = dir_y_q ^ hit_y;
    end

    // Datapath: wall/platform bounces are judged on the post-hit direction and replace it.
    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        case (state_q)
            ST_MOVING: begin
                dir_x_d = eff_dx;
                dir_y_d = eff_dy;
                if (tick) begin
                    if (eff_dx && ball_x_q == MAX_X)       dir_x_d  = 1'b0;
                    else if (!eff_dx && ball_x_q == 10'd0) dir_x_d  = 1'b1;
                    else if (eff_dx)                       ball_x_d = ball_x_q + 10'd1;
                    else                                   ball_x_d = ball_x_q - 10'd1;

                    if (!eff_dy && ball_y_q == 10'd0)                   dir_y_d  = 1'b1;
                    else if (eff_dy && ball_y_q == PLAT_ABOVE && on_plat) dir_y_d  = 1'b0;
                    else if (eff_dy)                                    ball_y_d = ball_y_q + 10'd1;
                    else                                                ball_y_d = ball_y_q - 10'd1;
                end
            end
            ST_LOST: begin
            end
            default: begin
                if (launch) begin
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end else begin
                    ball_x_d = park_x;
                    ball_y_d = START_Y;
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MOVING: if (ball_y_d == MAX_Y) state_d = ST_LOST;
            ST_LOST:   if (respawn)           state_d = ST_PARKED;
            default:   state_d = launch ? ST_MOVING : ST_PARKED;
        endcase
        lost_pulse_d = (state_q == ST_MOVING) && (state_d == ST_LOST);
    end

    always_comb begin
        ball_x     = ball_x_q;
        ball_y     = ball_y_q;
        dir_x      = dir_x_q;
        dir_y      = dir_y_q;
        state      = state_q;
        lost_pulse = lost_pulse_q;
    end

endmodule

// File: tb/tb_ball_mover.sv
// tb/tb_ball_mover.sv - directed and randomized checks of ball_mover against a reference model
module tb_ball_mover;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0, launch = 1'b0, respawn = 1'b0, hit_x = 1'b0, hit_y = 1'b0;
    logic [9:0] plat_x = 10'd0;
    logic [9:0] ball_x, ball_y;
    logic       dir_x, dir_y, lost_pulse;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int mx, my, mdx, mdy, mst, mpulse;

    ball_mover dut (
        .clk(clk), .resetn(resetn), .tick(tick), .launch(launch), .respawn(respawn),
        .plat_x(plat_x), .hit_x(hit_x), .hit_y(hit_y), .ball_x(ball_x), .ball_y(ball_y),
        .dir_x(dir_x), .dir_y(dir_y), .state(state), .lost_pulse(lost_pulse)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        tick = 1'b0;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
    endtask

    task automatic chk_pos(input string nm, input int ex, input int ey, input int est);
        n_cmp++;
        if (ball_x !== 10'(ex) || ball_y !== 10'(ey) || state !== 2'(est)) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d st=%0d, want x=%0d y=%0d st=%0d",
                     nm, ball_x, ball_y, state, ex, ey, est);
        end
    endtask

    task automatic chk_dir(input string nm, input int edx, input int edy);
        n_cmp++;
        if (dir_x !== 1'(edx) || dir_y !== 1'(edy)) begin
            n_bad++;
            $display("FAIL %s: got dx=%0d dy=%0d, want dx=%0d dy=%0d", nm, dir_x, dir_y, edx, edy);
        end
    endtask

    task automatic chk_pulse(input string nm, input logic ep);
        n_cmp++;
        if (lost_pulse !== ep) begin
            n_bad++;
            $display("FAIL %s: got lost_pulse=%0d want %0d", nm, lost_pulse, ep);
        end
    endtask

    task automatic test_reset;
        plat_x = 10'd300; tick = 1'b1; launch = 1'b1; hit_x = 1'b1;
        do_reset();
        tick = 1'b0; launch = 1'b0; hit_x = 1'b0;
        chk_pos("reset_pos", 80, 109, 0);
        chk_dir("reset_dir", 1, 0);
        chk_pulse("reset_pulse", 1'b0);
    endtask

    task automatic test_parked;
        do_reset();
        plat_x = 10'd50; tick = 1'b1; hit_x = 1'b1; hit_y = 1'b1; respawn = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        tick = 1'b0; hit_x = 1'b0; hit_y = 1'b0; respawn = 1'b0;
        chk_pos("park_follow", 60, 109, 0);
        chk_dir("park_ignores_hits", 1, 0);
        plat_x = 10'd150;
        cyc();
        chk_pos("park_clamp", 159, 109, 0);
    endtask

    task automatic test_launch;
        do_reset();
        plat_x = 10'd50;
        cyc();
        launch = 1'b1; respawn = 1'b1;
        cyc();
        launch = 1'b0; respawn = 1'b0;
        chk_pos("launch_hold", 60, 109, 1);
        chk_dir("launch_dir", 1, 0);
        ticks(3);
        chk_pos("launch_3ticks", 63, 106, 1);
        respawn = 1'b1; plat_x = 10'd0;
        cyc();
        respawn = 1'b0;
        chk_pos("moving_ignores_respawn", 63, 106, 1);
    endtask

    task automatic test_right_wall;
        do_reset();
        plat_x = 10'd150;
        cyc();
        launch = 1'b1; cyc(); launch = 1'b0;
        ticks(1);
        chk_pos("rwall_hold", 159, 108, 1);
        chk_dir("rwall_flip", 0, 0);
        ticks(1);
        chk_pos("rwall_leave", 158, 107, 1);
    endtask

    task automatic test_platform_and_loss;
        do_reset();
        plat_x = 10'd45;
        cyc();
        launch = 1'b1; cyc(); launch = 1'b0;
        ticks(3);
        hit_x = 1'b1; hit_y = 1'b1; cyc(); hit_x = 1'b0; hit_y = 1'b0;
        chk_dir("hit_only_dirs", 0, 1);
        chk_pos("hit_only_pos", 58, 106, 1);
        ticks(3);
        chk_pos("approach", 55, 109, 1);
        plat_x = 10'd50;
        ticks(1);
        chk_pos("plat_bounce", 54, 109, 1);
        chk_dir("plat_bounce_dir", 0, 0);
        ticks(3);
        hit_x = 1'b1; hit_y = 1'b1; cyc(); hit_x = 1'b0; hit_y = 1'b0;
        ticks(3);
        chk_pos("approach2", 54, 109, 1);
        plat_x = 10'd70;
        ticks(1);
        chk_pos("plat_miss", 55, 110, 1);
        ticks(8);
        chk_pos("falling", 63, 118, 1);
        chk_pulse("no_pulse_yet", 1'b0);
        ticks(1);
        chk_pos("lost_entry", 64, 119, 2);
        chk_pulse("lost_pulse_on", 1'b1);
        tick = 1'b1; hit_x = 1'b1; hit_y = 1'b1; launch = 1'b1;
        cyc();
        tick = 1'b0; hit_x = 1'b0; hit_y = 1'b0; launch = 1'b0;
        chk_pulse("lost_pulse_off", 1'b0);
        chk_pos("lost_frozen", 64, 119, 2);
        chk_dir("lost_frozen_dir", 1, 1);
        respawn = 1'b1; cyc(); respawn = 1'b0;
        chk_pos("respawn_state", 64, 119, 0);
        cyc();
        chk_pos("respawn_park", 80, 109, 0);
    endtask

    task automatic test_top_wall_hit;
        do_reset();
        plat_x = 10'd50;
        cyc();
        launch = 1'b1; cyc(); launch = 1'b0;
        ticks(109);
        chk_pos("top_reached", 150, 0, 1);
        chk_dir("top_dir", 0, 0);
        hit_y = 1'b1; tick = 1'b1;
        cyc();
        hit_y = 1'b0; tick = 1'b0;
        chk_pos("top_hit_tick", 149, 1, 1);
        chk_dir("top_hit_dir", 0, 1);
    endtask

    task automatic test_reset_moving;
        do_reset();
        plat_x = 10'd21;
        cyc();
        launch = 1'b1; cyc(); launch = 1'b0;
        ticks(69);
        chk_pos("pre_reset", 100, 40, 1);
        resetn = 1'b0; tick = 1'b1; launch = 1'b1; hit_x = 1'b1;
        cyc();
        resetn = 1'b1; tick = 1'b0; launch = 1'b0; hit_x = 1'b0;
        chk_pos("reset_mid_move", 80, 109, 0);
        chk_dir("reset_mid_move_dir", 1, 0);
        cyc();
        chk_pos("first_after_reset", 31, 109, 0);
    endtask

    task automatic model_step(input bit rn, input bit t, input bit l, input bit r,
                              input bit hx, input bit hy, input int px);
        int ny;
        mpulse = 0;
        if (!rn) begin
            mst = 0; mx = 80; my = 109; mdx = 1; mdy = 0;
        end else if (mst == 0) begin
            if (l) begin
                mst = 1; mdx = 1; mdy = 0;
            end else begin
                mx = (px + 10 > 159) ? 159 : px + 10;
                my = 109;
            end
        end else if (mst == 1) begin
            if (hx) mdx = 1 - mdx;
            if (hy) mdy = 1 - mdy;
            if (t) begin
                ny = my;
                if (mdy == 0 && my == 0) mdy = 1;
                else if (mdy == 1 && my == 109 && mx >= px && mx <= px + 19) mdy = 0;
                else ny = (mdy == 1) ? my + 1 : my - 1;
                if (mdx == 1 && mx == 159) mdx = 0;
                else if (mdx == 0 && mx == 0) mdx = 1;
                else mx = (mdx == 1) ? mx + 1 : mx - 1;
                my = ny;
                if (my == 119) begin
                    mst = 2; mpulse = 1;
                end
            end
        end else begin
            if (r) mst = 0;
        end
    endtask

    task automatic test_random;
        int px;
        bit rn, t, l, r, hx, hy;
        do_reset();
        model_step(1'b0, 0, 0, 0, 0, 0, 0);
        px = 60;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) px = $urandom_range(200);
            rn = ($urandom_range(700) != 0);
            t  = ($urandom_range(1) == 1);
            l  = ($urandom_range(7) == 0);
            r  = ($urandom_range(3) == 0);
            hx = ($urandom_range(15) == 0);
            hy = ($urandom_range(15) == 0);
            resetn = rn; tick = t; launch = l; respawn = r; hit_x = hx; hit_y = hy;
            plat_x = 10'(px);
            cyc();
            model_step(rn, t, l, r, hx, hy, px);
            n_cmp++;
            if (ball_x !== 10'(mx) || ball_y !== 10'(my) || dir_x !== 1'(mdx) ||
                dir_y !== 1'(mdy) || state !== 2'(mst) || lost_pulse !== 1'(mpulse)) begin
                n_bad++;
                $display("FAIL random[%0d]: got x=%0d y=%0d dx=%0d dy=%0d st=%0d lp=%0d, want x=%0d y=%0d dx=%0d dy=%0d st=%0d lp=%0d",
                         i, ball_x, ball_y, dir_x, dir_y, state, lost_pulse,
                         mx, my, mdx, mdy, mst, mpulse);
            end
        end
        resetn = 1'b1; tick = 1'b0; launch = 1'b0; respawn = 1'b0; hit_x = 1'b0; hit_y = 1'b0;
    endtask

    initial begin
        test_reset();
        test_parked();
        test_launch();
        test_right_wall();
        test_platform_and_loss();
        test_top_wall_hit();
        test_reset_moving();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_mover.md
BALL_MOVER -- requirements
Module: ball_mover

Interface
REQ-001 Parameter MAX_X, 10'd159, rightmost legal ball column.
REQ-002 Parameter MAX_Y, 10'd119, bottom screen row; reaching it means the ball is lost.
REQ-003 Parameter PLATY, 10'd110, platform row; same value as the `PLATY macro.
REQ-004 Parameter PLAT_W, 10'd20, platform width in pixels.
REQ-005 Parameter START_Y, 10'd109, ball row while parked on the platform.
REQ-006 clk  input  1  system clock; all state changes on posedge clk.
REQ-007 resetn  input  1  reset, synchronous, active-low.
REQ-008 tick  input  1  one-cycle movement strobe (frame rate); the ball moves at most one pixel per axis per tick.
REQ-009 launch  input  1  one-cycle pulse that releases a parked ball.
REQ-010 respawn  input  1  one-cycle pulse that returns a lost ball to the platform.
REQ-011 plat_x  input  10  platform left column.
REQ-012 hit_x  input  1  brick collision pulse; reverses horizontal direction.
REQ-013 hit_y  input  1  brick collision pulse; reverses vertical direction.
REQ-014 ball_x  output  10  ball column (registered).
REQ-015 ball_y  output  10  ball row (registered); feeds the loss detector downstream.
REQ-016 dir_x  output  1  1 = moving right, 0 = moving left.
REQ-017 dir_y  output  1  1 = moving down, 0 = moving up.
REQ-018 state  output  2  00 PARKED, 01 MOVING, 10 LOST.
REQ-019 lost_pulse  output  1  one-cycle pulse on entry to LOST.

Function
REQ-020 PARKED, every cycle: ball_x <= min(plat_x + PLAT_W/2, MAX_X); ball_y <= START_Y; tick, hit_x and hit_y are ignored.
REQ-021 PARKED with launch=1: go to MOVING next cycle, with dir_x=1 and dir_y=0; position is unchanged in that cycle.
REQ-022 MOVING with hit_x=1: toggle dir_x on the same edge; the same applies to hit_y and dir_y; hits do not change position.
REQ-023 MOVING with tick=1: effective directions are the dir values after any same-cycle hit toggle.
REQ-024 X motion on tick:
 - Moving right with ball_x == MAX_X: dir_x <= 0, ball_x unchanged.
 - Moving left with ball_x == 0: dir_x <= 1, ball_x unchanged.
 - Otherwise: ball_x moves one pixel in dir_x.
REQ-025 Y motion on tick:
 - Moving up with ball_y == 0: dir_y <= 1, ball_y unchanged.
 - Platform bounce: moving down, ball_y == PLATY-1 and plat_x <= ball_x <= plat_x+PLAT_W-1 (inclusive, 10-bit compare with no wrap): dir_y <= 0, ball_y unchanged.
 - Otherwise: ball_y moves one pixel in dir_y; a miss lets the ball cross PLATY.
REQ-026 A hit toggle and a wall/platform bounce on the same axis in the same cycle: the bounce decision uses the post-hit direction, and the final direction is the bounce result; there is never a double toggle.
REQ-027 MOVING: when the updated ball_y equals MAX_Y, enter LOST on that edge and assert lost_pulse for exactly one cycle.
REQ-028 LOST: ball_x, ball_y, dir_x and dir_y are frozen; tick, hits and launch are ignored.
REQ-029 LOST with respawn=1: go to PARKED next cycle; respawn is ignored in other states.
REQ-030 launch and respawn are ignored in states where they are not listed; if both are asserted, only the one valid for the current state is acted on.
REQ-031 All arithmetic is 10-bit unsigned; the bounds checks above guarantee no underflow or overflow of ball_x or ball_y.

Reset
REQ-032 resetn=0 at a clock edge: state=PARKED, ball_x=80, ball_y=START_Y, dir_x=1, dir_y=0, lost_pulse=0.
REQ-033 Reset overrides every other input in the same cycle, including reset asserted mid-MOVING or in LOST.
REQ-034 The first cycle after reset follows REQ-020.

Verification
REQ-035 plat_x=50, parked, 5 cycles -> ball_x=60, ball_y=109; then plat_x=150 -> ball_x=159 (clamped).
REQ-036 Launch at ball_x=60, then 3 ticks -> ball_x=63, ball_y=106, state=01.
REQ-037 Ball at x=159, dir_x=1, tick -> dir_x=0, x=159; next tick -> x=158.
REQ-038 Ball down at y=109, x=55, plat_x=50, tick -> dir_y=0, y=109; repeat with plat_x=70 -> y=110, then after 9 more ticks -> y=119, state=10, lost_pulse high for one cycle only.
REQ-039 hit_y and tick together at y=0 while moving up -> dir_y=1 (post-hit direction, no wall toggle), y=1.
REQ-040 resetn=0 while MOVING at (100,40) -> next cycle state=00, ball_x=80, ball_y=109, dir_x=1, dir_y=0.
